// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request/result bundle between the pipeline and the
//                multiply/divide unit (operands, HI/LO writes, status, results).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if #(
    parameter int dataWidth = 32
) ();
    logic                 START;
    logic [1:0]           OP;
    logic [dataWidth-1:0] SRCA;
    logic [dataWidth-1:0] SRCB;
    logic                 HI_WE;
    logic                 LO_WE;
    logic [dataWidth-1:0] WD;
    logic                 BUSY;
    logic                 DONE;
    logic                 DIVZ;
    logic [dataWidth-1:0] HI;
    logic [dataWidth-1:0] LO;

    // Requester side: issues operations and HI/LO writes
    modport master (
        output START, OP, SRCA, SRCB, HI_WE, LO_WE, WD,
        input  BUSY, DONE, DIVZ, HI, LO
    );

    // Unit side
    modport slave (
        input  START, OP, SRCA, SRCB, HI_WE, LO_WE, WD,
        output BUSY, DONE, DIVZ, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative MIPS-style multiply/divide unit. Shift-add multiply
//                and restoring shift-subtract divide, one bit per cycle, on
//                operand magnitudes with a sign fix-up cycle. Results land in
//                the HI/LO registers, which can also be written directly.
//  Options     : `define MDU_EARLY_TERM_EN to stop multiply iterations once
//                the remaining multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int dataWidth = 32
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    mult_div_unit_if.slave bus
);
    localparam int W     = dataWidth;
    localparam int CNT_W = $clog2(dataWidth + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    // Multiply: prod_q accumulates, mcand_q shifts left, mplier_q shifts right.
    // Divide:   prod_q = {remainder, dividend/quotient}, mcand_q[W-1:0] = divisor.
    logic [2*W-1:0]   prod_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             divz_pend_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;
    logic             busy_q;
    logic             done_q;
    logic             divz_q;

    logic             op_div_d;
    logic             op_signed_d;
    logic [W-1:0]     mag_a_d;
    logic [W-1:0]     mag_b_d;
    logic [W:0]       rem_shift_d;
    logic             rem_ge_d;
    logic [W-1:0]     rem_sub_d;
    logic [W-1:0]     rem_fix_d;
    logic [W-1:0]     quo_fix_d;
    logic [2*W-1:0]   prod_step_d;
    logic [2*W-1:0]   fix_d;
    logic             last_iter_d;

    // Operand magnitudes, one iteration step, last-iteration detect and sign fix-up
    always_comb begin
        op_div_d    = bus.OP[1];
        op_signed_d = bus.OP[0];
        mag_a_d     = (op_signed_d && bus.SRCA[W-1]) ? -bus.SRCA : bus.SRCA;
        mag_b_d     = (op_signed_d && bus.SRCB[W-1]) ? -bus.SRCB : bus.SRCB;

        // Remainder is kept one bit wider while shifting so the trial compare
        // never loses the bit shifted out of the top.
        rem_shift_d = prod_q[2*W-1:W-1];
        rem_ge_d    = (rem_shift_d >= {1'b0, mcand_q[W-1:0]});
        rem_sub_d   = rem_shift_d[W-1:0] - mcand_q[W-1:0];

        if (is_div_q) begin
            prod_step_d = rem_ge_d ? {rem_sub_d, prod_q[W-2:0], 1'b1}
                                   : {rem_shift_d[W-1:0], prod_q[W-2:0], 1'b0};
        end else begin
            prod_step_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        end

`ifdef MDU_EARLY_TERM_EN
        last_iter_d = (cnt_q == CNT_W'(W - 1)) ||
                      (!is_div_q && (mplier_q[W-1:1] == '0));
`else
        last_iter_d = (cnt_q == CNT_W'(W - 1));
`endif

        rem_fix_d = neg_rem_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];
        quo_fix_d = neg_res_q ? -prod_q[W-1:0]   : prod_q[W-1:0];
        if (is_div_q) begin
            fix_d = {rem_fix_d, quo_fix_d};
        end else begin
            fix_d = neg_res_q ? -prod_q : prod_q;
        end
    end

    // Control FSM with datapath registers and registered status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            divz_pend_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            divz_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.HI_WE) hi_q <= bus.WD;
                    if (bus.LO_WE) lo_q <= bus.WD;
                    if (bus.START) begin
                        is_div_q  <= op_div_d;
                        neg_res_q <= op_signed_d && (bus.SRCA[W-1] ^ bus.SRCB[W-1]);
                        neg_rem_q <= op_signed_d && op_div_d && bus.SRCA[W-1];
                        cnt_q     <= '0;
                        if (op_div_d) begin
                            prod_q   <= {{W{1'b0}}, mag_a_d};
                            mcand_q  <= {{W{1'b0}}, mag_b_d};
                            mplier_q <= '0;
                        end else begin
                            prod_q   <= '0;
                            mcand_q  <= {{W{1'b0}}, mag_a_d};
                            mplier_q <= mag_b_d;
                        end
                        if (op_div_d && (bus.SRCB == '0)) begin
                            divz_pend_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            divz_pend_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    prod_q <= prod_step_d;
                    if (!is_div_q) begin
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter_d) state_q <= S_FIX;
                end
                S_FIX: begin
                    prod_q  <= fix_d;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    if (divz_pend_q) begin
                        divz_q <= 1'b1;
                    end else begin
                        hi_q <= prod_q[2*W-1:W];
                        lo_q <= prod_q[W-1:0];
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.DIVZ = divz_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter dataWidth, default 32, operand/result width.
REQ-002 SHALL have port CLK input 1, single clock; all state updates on posedge CLK.
REQ-003 SHALL have port RST input 1, synchronous active-high reset.
REQ-004 SHALL have port START input 1, request an operation; sampled at posedge.
REQ-005 SHALL have port OP input 2, operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port SRCA input dataWidth, multiplicand/dividend, driven from register-file RD1.
REQ-007 SHALL have port SRCB input dataWidth, multiplier/divisor, driven from register-file RD2.
REQ-008 SHALL have port HI_WE input 1, direct write of HI from WD (mthi).
REQ-009 SHALL have port LO_WE input 1, direct write of LO from WD (mtlo).
REQ-010 SHALL have port WD input dataWidth, data for HI_WE/LO_WE.
REQ-011 SHALL have port BUSY output 1, operation in progress.
REQ-012 SHALL have port DONE output 1, one-cycle pulse on operation completion.
REQ-013 SHALL have port DIVZ output 1, divide-by-zero flag, valid while DONE=1.
REQ-014 SHALL have ports HI and LO output dataWidth, registered result halves, read asynchronously by mfhi/mflo.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX, DONE; IDLE->RUN on START; RUN->FIX after dataWidth iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-016 SHALL latch SRCA, SRCB, OP at the edge START is sampled in IDLE; later input changes have no effect.
REQ-017 SHALL ignore START in RUN, FIX, DONE states.
REQ-018 SHALL drive BUSY=1 in RUN and FIX, BUSY=0 in IDLE and DONE.
REQ-019 SHALL, for START sampled at edge 0, update HI/LO and raise DONE at edge dataWidth+2 (34 cycles for 32), DONE low one edge later.
REQ-020 SHALL multiply by iterative shift-add, one multiplier bit per RUN cycle, full 2*dataWidth product: HI=upper half, LO=lower half.
REQ-021 SHALL divide by restoring shift-subtract, one quotient bit per RUN cycle: LO=quotient, HI=remainder.
REQ-022 SHALL for signed ops iterate on magnitudes and negate results in FIX: product negative iff operand signs differ; quotient truncated toward zero; remainder takes sign of dividend.
REQ-023 SHALL for DIV of most-negative value by -1 yield LO=most-negative value (0x80000000 at 32), HI=0, DIVZ=0.
REQ-024 SHALL on DIV/DIVU with SRCB=0 skip RUN/FIX, go IDLE->DONE, pulse DONE and DIVZ at edge 1, leave HI/LO unchanged.
REQ-025 SHALL perform HI_WE/LO_WE writes only in IDLE; ignore them in other states.
REQ-026 SHALL, on HI_WE/LO_WE and START sampled at the same edge in IDLE, perform the write and start the operation; the later result overwrites.
REQ-027 SHALL hold DIVZ=0 except during a DONE pulse of a divide-by-zero operation.

Reset
REQ-028 SHALL on RST=1 at posedge force state IDLE, HI=0, LO=0, BUSY=0, DONE=0, DIVZ=0, clear iteration counter and working registers.
REQ-029 SHALL on RST mid-operation abort without updating HI/LO beyond the reset value and without a DONE pulse.
REQ-030 SHALL give RST priority over START, HI_WE, LO_WE.

Configuration
REQ-031 SHALL, with macro MDU_EARLY_TERM_EN defined, end RUN for MULT/MULTU after the iteration where remaining multiplier magnitude bits are all zero, minimum 1 iteration, with FIX/DONE timing relative to last iteration unchanged; results identical.
REQ-032 SHALL, without MDU_EARLY_TERM_EN, use fixed dataWidth iterations for all operations; divide latency unaffected in both builds.

Verification
REQ-033 SHALL test MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, DONE at edge 34 (no macro).
REQ-034 SHALL test MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; with MDU_EARLY_TERM_EN, DONE at edge 5 (3 iterations).
REQ-035 SHALL test DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-036 SHALL test DIVU 5/0 with HI=0x11, LO=0x22 preloaded via HI_WE/LO_WE -> DONE and DIVZ at edge 1, HI=0x11, LO=0x22.
REQ-037 SHALL test RST at edge 10 of a MULTU -> HI=LO=0, BUSY=0, no DONE; START re-issued at edge 12 during a busy test -> ignored.
